// File: rtl/stopwatch_lapbank.sv
// stopwatch_lapbank: BCD stopwatch (cen/dec/s0/s1/min) driven by a divided tick
// enable, a LAP_DEPTH-slot lap memory (fill-and-stop or circular overwrite), and
// a multiplexed 4-digit common-anode scan driver with a minutes bargraph.
module stopwatch_lapbank #(
    parameter int CLK_DIV   = 500000,
    parameter int SCAN_DIV  = 8192,
    parameter int LAP_DEPTH = 4,
    parameter int LAP_WRAP  = 0,
    parameter int MAX_MIN   = 9,
    localparam int LW       = $clog2(LAP_DEPTH)
) (
    input  logic          clk_50M,
    input  logic          reset,
    input  logic          pause,
    input  logic          lap_pulse,
    input  logic          clear_laps,
    input  logic          show_lap,
    input  logic [LW-1:0] lap_sel,
    output logic [3:0]    digit,
    output logic [3:0]    an,
    output logic          dp,
    output logic [7:0]    leds,
    output logic [LW:0]   lap_count,
    output logic          lap_full,
    output logic          lap_valid
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef struct packed {
        logic [3:0] mn;
        logic [3:0] s1;
        logic [3:0] s0;
        logic [3:0] dec;
        logic [3:0] cen;
    } tm_t;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [SW-1:0] scan_q, scan_d;
    logic          scan_wrap;
    logic [1:0]    pos_q, pos_d;
    tm_t           tm_q, tm_d;
    tm_t           mem_q [LAP_DEPTH];
    logic [LW:0]   lap_cnt_q, lap_cnt_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_idx;
    logic          full, lap_wr;
    tm_t           disp;

    assign tick      = (div_q == DW'(CLK_DIV - 1));
    assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
    assign full      = (lap_cnt_q == (LW+1)'(LAP_DEPTH));
    // A full memory only accepts captures when it is allowed to overwrite the oldest slot.
    assign lap_wr    = lap_pulse && !clear_laps && (!full || (LAP_WRAP != 0));

    // Free-running divider and scan counter; neither is affected by pause.
    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        scan_d = scan_wrap ? '0 : scan_q + 1'b1;
        pos_d  = pos_q + {1'b0, scan_wrap};
    end

    // BCD ripple: every carry is resolved in the same edge, including the full-time wrap.
    always_comb begin
        tm_d = tm_q;
        if (tick && !pause) begin
            if (tm_q.cen != 4'd9) tm_d.cen = tm_q.cen + 4'd1;
            else begin
                tm_d.cen = '0;
                if (tm_q.dec != 4'd9) tm_d.dec = tm_q.dec + 4'd1;
                else begin
                    tm_d.dec = '0;
                    if (tm_q.s0 != 4'd9) tm_d.s0 = tm_q.s0 + 4'd1;
                    else begin
                        tm_d.s0 = '0;
                        if (tm_q.s1 != 4'd5) tm_d.s1 = tm_q.s1 + 4'd1;
                        else begin
                            tm_d.s1 = '0;
                            tm_d.mn = (tm_q.mn != 4'(MAX_MIN)) ? tm_q.mn + 4'd1 : 4'd0;
                        end
                    end
                end
            end
        end
    end

    // Lap bookkeeping: clear dominates; a wrap-mode write to a full memory keeps the count.
    always_comb begin
        lap_cnt_d = lap_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        if (clear_laps) begin
            lap_cnt_d = '0;
            wr_ptr_d  = '0;
        end else if (lap_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!full) lap_cnt_d = lap_cnt_q + 1'b1;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            scan_q    <= '0;
            pos_q     <= '0;
            tm_q      <= '0;
            lap_cnt_q <= '0;
            wr_ptr_q  <= '0;
        end else begin
            div_q     <= div_d;
            scan_q    <= scan_d;
            pos_q     <= pos_d;
            tm_q      <= tm_d;
            lap_cnt_q <= lap_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Lap slots capture the pre-increment time of the capture cycle.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
        end else if (lap_wr) begin
            mem_q[wr_ptr_q] <= tm_q;
        end
    end

    // Once full, the oldest lap sits at wr_ptr, so index relative to it.
    always_comb begin
        rd_idx    = full ? wr_ptr_q + lap_sel : lap_sel;
        lap_valid = show_lap && ({1'b0, lap_sel} < lap_cnt_q);
        disp      = tm_q;
        if (show_lap) disp = lap_valid ? mem_q[rd_idx] : '0;
    end

    // Scan mux, active-low anodes/dp, and saturating minutes thermometer.
    always_comb begin
        case (pos_q)
            2'd0:    digit = disp.cen;
            2'd1:    digit = disp.dec;
            2'd2:    digit = disp.s0;
            default: digit = disp.s1;
        endcase
        an = ~(4'b0001 << pos_q);
        dp = (pos_q != 2'd2);
        for (int i = 0; i < 8; i++) leds[i] = (disp.mn >= 4'(i + 1));
    end

    assign lap_count = lap_cnt_q;
    assign lap_full  = full;

endmodule

// File: tb/tb_stopwatch_lapbank.sv
// Bench for stopwatch_lapbank: two instances (fill-and-stop and circular) share
// stimulus; a tick/lap model feeds expected values through queues.
`timescale 1ns/1ps
module tb_stopwatch_lapbank;
    localparam int CD = 4, SD = 2, LD = 4, MM = 1;

    logic       clk_50M = 1'b0, reset = 1'b1, pause = 1'b0, lap_pulse = 1'b0;
    logic       clear_laps = 1'b0, show_lap = 1'b0;
    logic [1:0] lap_sel = '0;
    logic [3:0] digit0, digit1, an0, an1;
    logic       dp0, dp1, full0, full1, valid0, valid1;
    logic [7:0] leds0, leds1;
    logic [2:0] cnt0, cnt1;

    stopwatch_lapbank #(.CLK_DIV(CD), .SCAN_DIV(SD), .LAP_DEPTH(LD), .LAP_WRAP(0), .MAX_MIN(MM)) dut0 (
        .clk_50M(clk_50M), .reset(reset), .pause(pause), .lap_pulse(lap_pulse),
        .clear_laps(clear_laps), .show_lap(show_lap), .lap_sel(lap_sel),
        .digit(digit0), .an(an0), .dp(dp0), .leds(leds0), .lap_count(cnt0),
        .lap_full(full0), .lap_valid(valid0));

    stopwatch_lapbank #(.CLK_DIV(CD), .SCAN_DIV(SD), .LAP_DEPTH(LD), .LAP_WRAP(1), .MAX_MIN(MM)) dut1 (
        .clk_50M(clk_50M), .reset(reset), .pause(pause), .lap_pulse(lap_pulse),
        .clear_laps(clear_laps), .show_lap(show_lap), .lap_sel(lap_sel),
        .digit(digit1), .an(an1), .dp(dp1), .leds(leds1), .lap_count(cnt1),
        .lap_full(full1), .lap_valid(valid1));

    always #5 clk_50M = ~clk_50M;

    int tests = 0, fails = 0;
    int ec, mt;              // edges since reset, model tick count
    int q0[$], q1[$];        // expected lap contents (tick counts), oldest first
    logic [19:0] exp_q[$];   // expected live display values

    // Reference model: a tick every CD edges after reset, laps as tick counts.
    always @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            ec = 0; mt = 0; q0.delete(); q1.delete();
        end else begin
            if (clear_laps) begin
                q0.delete(); q1.delete();
            end else if (lap_pulse) begin
                if (q0.size() < LD) q0.push_back(mt);
                if (q1.size() == LD) void'(q1.pop_front());
                q1.push_back(mt);
            end
            ec = ec + 1;
            if ((ec % CD) == 0 && !pause) mt = mt + 1;
        end
    end

    function automatic logic [19:0] to_bcd(input int t);
        int r, s, c;
        t = t % ((MM + 1) * 6000);
        r = t % 6000; s = r / 100; c = r % 100;
        return {4'(t / 6000), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [7:0] thermo(input logic [3:0] m);
        logic [7:0] th;
        for (int i = 0; i < 8; i++) th[i] = (int'(m) >= i + 1);
        return th;
    endfunction

    task automatic read_disp(output logic [15:0] d0, output logic [15:0] d1);
        logic [3:0] ea;
        int n;
        d0 = '0; d1 = '0;
        for (int p = 0; p < 4; p++) begin
            ea = ~(4'b0001 << p);
            n = 0;
            @(negedge clk_50M);
            while (an0 !== ea && n < 16) begin @(negedge clk_50M); n++; end
            if (an0 !== ea) begin
                tests++; fails++;
                $display("FAIL scan_timeout pos=%0d an=%b", p, an0);
            end
            d0[p*4 +: 4] = digit0;
            d1[p*4 +: 4] = digit1;
        end
    endtask

    task automatic wait_mt(input int target);
        int n = 0;
        while (mt < target && n < 30000) begin @(negedge clk_50M); n++; end
        if (mt != target) begin
            tests++; fails++;
            $display("FAIL wait_ticks got=%0d want=%0d", mt, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        reset = 1'b1; pause = 0; lap_pulse = 0; clear_laps = 0; show_lap = 0; lap_sel = 0;
        @(negedge clk_50M);
        reset = 1'b0;
    endtask

    // Freeze time, record the model's value, then read back and compare live display.
    task automatic freeze_check(input string tag);
        logic [15:0] d0, d1;
        logic [19:0] e;
        pause = 1'b1;
        show_lap = 1'b0;
        exp_q.push_back(to_bcd(mt));
        read_disp(d0, d1);
        e = exp_q.pop_front();
        tests++; if (d0 !== e[15:0]) begin fails++; $display("FAIL %s_live0 got=%h want=%h", tag, d0, e[15:0]); end
        tests++; if (d1 !== e[15:0]) begin fails++; $display("FAIL %s_live1 got=%h want=%h", tag, d1, e[15:0]); end
        tests++; if (leds0 !== thermo(e[19:16])) begin fails++; $display("FAIL %s_leds got=%b want=%b", tag, leds0, thermo(e[19:16])); end
    endtask

    task automatic test_reset();
        tests++; if (an0 !== 4'b1110 || digit0 !== 4'd0 || dp0 !== 1'b1) begin fails++; $display("FAIL reset_scan an=%b digit=%h dp=%b want 1110/0/1", an0, digit0, dp0); end
        tests++; if (leds0 !== 8'd0 || valid0 !== 1'b0) begin fails++; $display("FAIL reset_leds leds=%b valid=%b want 0/0", leds0, valid0); end
        tests++; if (cnt0 !== 3'd0 || full0 !== 1'b0) begin fails++; $display("FAIL reset_laps cnt=%0d full=%b want 0/0", cnt0, full0); end
        // reset mid-count and right after a capture
        reset = 1'b0;
        repeat (41) @(negedge clk_50M);
        lap_pulse = 1'b1;
        @(posedge clk_50M); #2;
        reset = 1'b1; lap_pulse = 1'b0;
        #1;
        tests++; if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin fails++; $display("FAIL reset_async_cnt cnt0=%0d cnt1=%0d want 0", cnt0, cnt1); end
        tests++; if (an0 !== 4'b1110 || digit0 !== 4'd0 || dp0 !== 1'b1) begin fails++; $display("FAIL reset_async_scan an=%b digit=%h dp=%b", an0, digit0, dp0); end
        @(negedge clk_50M);
        reset = 1'b0;
    endtask

    task automatic test_count();
        logic [15:0] d0, d1;
        wait_mt(1000);
        freeze_check("count1000");
        read_disp(d0, d1);
        tests++; if (d0 !== 16'h1000) begin fails++; $display("FAIL count_10s got=%h want=1000", d0); end
    endtask

    task automatic test_pause();
        int frozen, n;
        frozen = mt;
        repeat (CD * 50) @(negedge clk_50M);
        freeze_check("pause_hold");
        tests++; if (mt != frozen) begin fails++; $display("FAIL pause_model got=%0d want=%0d", mt, frozen); end
        pause = 1'b0;
        n = 0;
        while (mt == frozen && n < 2 * CD) begin @(negedge clk_50M); n++; end
        tests++; if (n > CD) begin fails++; $display("FAIL pause_resume_latency got=%0d want<=%0d", n, CD); end
        freeze_check("pause_resume");
    endtask

    task automatic test_minute();
        pause = 1'b0;
        wait_mt(6000);
        freeze_check("min1");
        tests++; if (leds0 !== 8'b00000001) begin fails++; $display("FAIL min1_leds got=%b want=00000001", leds0); end
        pause = 1'b0;
        wait_mt(12000);
        freeze_check("wrap");
        tests++; if (leds0 !== 8'd0 || digit0 !== 4'd0) begin fails++; $display("FAIL wrap_zero leds=%b digit=%h want 0", leds0, digit0); end
    endtask

    task automatic test_laps();
        logic [15:0] d0, d1;
        logic [19:0] e0, e1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            wait_mt(k);
            lap_pulse = 1'b1;
            @(negedge clk_50M);
            lap_pulse = 1'b0;
            tests++; if (cnt0 !== 3'(q0.size()) || cnt1 !== 3'(q1.size())) begin fails++; $display("FAIL lap_count_%0d got=%0d/%0d want=%0d/%0d", k, cnt0, cnt1, q0.size(), q1.size()); end
        end
        tests++; if (cnt0 !== 3'd4 || full0 !== 1'b1 || full1 !== 1'b1) begin fails++; $display("FAIL lap_full cnt=%0d full0=%b full1=%b want 4/1/1", cnt0, full0, full1); end
        pause = 1'b1;
        show_lap = 1'b1;
        for (int s = 0; s < LD; s++) begin
            lap_sel = 2'(s);
            read_disp(d0, d1);
            e0 = to_bcd(q0[s]);
            e1 = to_bcd(q1[s]);
            tests++; if (d0 !== e0[15:0] || valid0 !== 1'b1) begin fails++; $display("FAIL lap_fill_sel%0d got=%h valid=%b want=%h", s, d0, valid0, e0[15:0]); end
            tests++; if (d1 !== e1[15:0] || valid1 !== 1'b1) begin fails++; $display("FAIL lap_wrap_sel%0d got=%h valid=%b want=%h", s, d1, valid1, e1[15:0]); end
            if (s == 0) begin tests++; if (d1 !== 16'h0002) begin fails++; $display("FAIL lap_wrap_oldest got=%h want=0002", d1); end end
            if (s == 3) begin tests++; if (d1 !== 16'h0005) begin fails++; $display("FAIL lap_wrap_newest got=%h want=0005", d1); end end
        end
        show_lap = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_coincident();
        logic [15:0] d0, d1;
        do_reset();
        wait_mt(9);
        while ((ec % CD) != CD - 1) @(negedge clk_50M);
        lap_pulse = 1'b1;            // next edge is a tick: 0:00.09 -> 0:00.10
        @(negedge clk_50M);
        lap_pulse = 1'b0;
        freeze_check("coinc_live");
        show_lap = 1'b1; lap_sel = 2'd0;
        read_disp(d0, d1);
        tests++; if (d0 !== 16'h0009 || d1 !== 16'h0009) begin fails++; $display("FAIL coinc_lap got=%h/%h want=0009", d0, d1); end
        lap_sel = 2'd1;
        #1;
        tests++; if (valid0 !== 1'b0 || digit0 !== 4'd0) begin fails++; $display("FAIL lap_sel_invalid valid=%b digit=%h want 0/0", valid0, digit0); end
        show_lap = 1'b0;
        @(negedge clk_50M);
        clear_laps = 1'b1; lap_pulse = 1'b1;
        @(negedge clk_50M);
        clear_laps = 1'b0; lap_pulse = 1'b0;
        tests++; if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin fails++; $display("FAIL clear_vs_pulse cnt=%0d/%0d want 0", cnt0, cnt1); end
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        int n = 0;
        show_lap = 1'b1; lap_sel = 2'd0;
        while (an0 !== 4'b0111 && n < 16) begin @(negedge clk_50M); n++; end
        while (an0 !== 4'b1110 && n < 32) begin @(negedge clk_50M); n++; end
        tests++; if (an0 !== 4'b1110) begin fails++; $display("FAIL scan_sync an=%b want=1110", an0); end
        for (int k = 0; k < 4 * SD; k++) begin
            ea = ~(4'b0001 << (k / SD));
            tests++;
            if (an0 !== ea || dp0 !== (k / SD != 2) || digit0 !== 4'd0 || valid0 !== 1'b0 || leds0 !== 8'd0) begin
                fails++;
                $display("FAIL scan_step%0d an=%b dp=%b digit=%h valid=%b want an=%b dp=%b digit=0 valid=0", k, an0, dp0, digit0, valid0, ea, (k / SD != 2));
            end
            @(negedge clk_50M);
        end
        show_lap = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_50M);
        test_reset();
        test_count();
        test_pause();
        test_minute();
        test_laps();
        test_coincident();
        test_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
